// File: rtl/warmboot_pkg.sv
// warmboot_pkg
// Shared types and constants for the warm-boot sequencer:
//   state_t  - controller states (IDLE, SETUP, FIRE, DONE)
//   IMG_W    - width of an image select ({S1,S0})
//   IMG0..3  - image select encodings for the four bitstream images
package warmboot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IMG_W = 2;

  localparam logic [IMG_W-1:0] IMG0 = 2'b00;
  localparam logic [IMG_W-1:0] IMG1 = 2'b01;
  localparam logic [IMG_W-1:0] IMG2 = 2'b10;
  localparam logic [IMG_W-1:0] IMG3 = 2'b11;

endpackage

// File: rtl/warmboot_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. The winner is the first asserted request
// strictly after the 'last' index, wrapping modulo NREQ.
// Ports:
//   req      in  NREQ  request vector
//   last     in  IW    index of the previous winner
//   win      out NREQ  one-hot winner (all zero when no request)
//   win_idx  out IW    index of the winner
//   valid    out 1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            valid
);

  always_comb begin
    int cand;
    cand    = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    // Scan offsets 1..NREQ so 'last' itself is considered only after a full lap.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid   = 1'b1;
        win_idx = IW'(cand);
      end
    end
    if (valid) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl
// Arbitrates reboot requests and sequences the SB_WARMBOOT controls: image
// select held stable for SETTLE cycles, then BOOT pulsed for HOLD cycles.
// Ports:
//   clk        in  1       clock
//   rst        in  1       async active-high reset
//   enable     in  1       permission for new grants; low in SETUP cancels
//   req        in  NREQ    level requests
//   req_image  in  2*NREQ  image per requester, bits [2i+1:2i] = {S1,S0}
//   cancel     in  1       abort while in SETUP
//   gnt        out NREQ    one-cycle one-hot grant pulse
//   busy       out 1       high in SETUP, FIRE, DONE
//   wb_s1/s0   out 1       registered image select
//   wb_boot    out 1       registered BOOT strobe
//
// state | meaning
// IDLE  | waiting for enable && request
// SETUP | image select driven, settle countdown
// FIRE  | BOOT high, hold countdown
// DONE  | terminal, device reconfigures; only rst leaves
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 16,
  parameter int HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [IMG_W*NREQ-1:0] req_image,
  input  logic                  cancel,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  wb_s1,
  output logic                  wb_s0,
  output logic                  wb_boot
);

  localparam int CMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IMG_W-1:0]  sel_q, sel_d;
  logic              boot_q, boot_d;

  logic [NREQ-1:0]   win;
  logic [IW-1:0]     win_idx;
  logic              win_valid;
  logic [IMG_W-1:0]  win_img;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  always_comb begin
    win_img = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) win_img = req_image[IMG_W*i +: IMG_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      boot_q  <= boot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = '0;
    sel_d   = sel_q;
    boot_d  = boot_q;
    case (state_q)
      IDLE: begin
        if (enable && win_valid) begin
          state_d = SETUP;
          sel_d   = win_img;
          gnt_d   = win;
          last_d  = win_idx;
          cnt_d   = CW'(SETTLE - 1);
        end
      end
      SETUP: begin
        // Abort wins over expiry so a late cancel never lets BOOT rise.
        if (cancel || !enable) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = FIRE;
          boot_d  = 1'b1;
          cnt_d   = CW'(HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIRE: begin
        if (cnt_q == '0) begin
          boot_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        boot_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign wb_s1   = sel_q[1];
  assign wb_s0   = sel_q[0];
  assign wb_boot = boot_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
module tb_warmboot_ctrl;

  localparam int NREQ   = 4;
  localparam int SETTLE = 16;
  localparam int HOLD   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NREQ-1:0]  req;
  logic [2*NREQ-1:0] req_image;
  logic             cancel;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             wb_s1;
  logic             wb_s0;
  logic             wb_boot;

  int total = 0;
  int bad   = 0;

  // Reference model: round-robin pointer only; timing is derived from
  // SETTLE/HOLD directly in each scenario.
  int m_last;

  warmboot_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .req_image (req_image),
    .cancel    (cancel),
    .gnt       (gnt),
    .busy      (busy),
    .wb_s1     (wb_s1),
    .wb_s0     (wb_s0),
    .wb_boot   (wb_boot)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    pick = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (pick < 0 && r[(last + k) % NREQ]) pick = (last + k) % NREQ;
    end
  endfunction

  function automatic logic [1:0] img_of(input logic [2*NREQ-1:0] imgs, input int w);
    logic [2*NREQ-1:0] t;
    t = imgs >> (2 * w);
    return t[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    req       = '0;
    req_image = '0;
    cancel    = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({gnt, busy, wb_s1, wb_s0, wb_boot} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b s=%b%b boot=%b want all 0",
               gnt, busy, wb_s1, wb_s0, wb_boot);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_s;
    do_reset();
    req_image = 8'($urandom);
    req_image[5:4] = 2'b11;
    req    = 4'b0100;
    enable = 1'b1;
    tick();
    exp_s = 2'b11;
    total++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || {wb_s1, wb_s0} !== exp_s) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b busy=%b s=%b%b want 0100 1 11",
               gnt, busy, wb_s1, wb_s0);
    end
    req = '0;
    for (int c = 1; c <= SETTLE + HOLD + 3; c++) begin
      logic exp_boot;
      tick();
      exp_boot = (c >= SETTLE) && (c < SETTLE + HOLD);
      total++;
      if (wb_boot !== exp_boot || gnt !== 4'b0 || {wb_s1, wb_s0} !== exp_s) begin
        bad++;
        $display("FAIL single_seq c=%0d: got boot=%b gnt=%b s=%b%b want boot=%b gnt=0000 s=%b",
                 c, wb_boot, gnt, wb_s1, wb_s0, exp_boot, exp_s);
      end
    end
    // DONE ignores everything.
    for (int c = 0; c < 10; c++) begin
      req       = 4'($urandom);
      req_image = 8'($urandom);
      cancel    = 1'($urandom);
      enable    = 1'($urandom);
      tick();
      total++;
      if (busy !== 1'b1 || wb_boot !== 1'b0 || gnt !== 4'b0 || {wb_s1, wb_s0} !== exp_s) begin
        bad++;
        $display("FAIL done_hold: got busy=%b boot=%b gnt=%b s=%b%b want 1 0 0000 %b",
                 busy, wb_boot, gnt, wb_s1, wb_s0, exp_s);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 1'b1;
    for (int round = 0; round < 25; round++) begin
      int w;
      logic [3:0] exp_g;
      logic [1:0] exp_s;
      // First five rounds are the all-request fairness sequence 0,1,2,3,0.
      req       = (round < 5) ? 4'b1111 : 4'($urandom_range(1, 15));
      req_image = 8'($urandom);
      w     = pick(req, m_last);
      exp_g = 4'b0001 << w;
      exp_s = img_of(req_image, w);
      tick();
      m_last = w;
      total++;
      if (gnt !== exp_g || {wb_s1, wb_s0} !== exp_s || busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant round=%0d: got gnt=%b s=%b%b busy=%b want gnt=%b s=%b busy=1",
                 round, gnt, wb_s1, wb_s0, busy, exp_g, exp_s);
      end
      // A few settle cycles, then abort by cancel or by dropping enable.
      for (int c = 0; c < int'($urandom_range(0, 5)); c++) tick();
      if ($urandom_range(0, 1) == 1) cancel = 1'b1;
      else enable = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || {wb_s1, wb_s0} !== 2'b00 || wb_boot !== 1'b0) begin
        bad++;
        $display("FAIL rr_abort round=%0d: got busy=%b s=%b%b boot=%b want 0 00 0",
                 round, busy, wb_s1, wb_s0, wb_boot);
      end
      cancel = 1'b0;
      enable = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_cancel_last();
    int boots;
    do_reset();
    req_image = 8'hFF;
    req       = 4'b0010;
    enable    = 1'b1;
    tick();
    req   = '0;
    boots = 0;
    for (int c = 1; c < SETTLE; c++) begin
      tick();
      if (wb_boot === 1'b1) boots++;
    end
    cancel = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || {wb_s1, wb_s0} !== 2'b00 || wb_boot !== 1'b0) begin
      bad++;
      $display("FAIL cancel_last: got busy=%b s=%b%b boot=%b want 0 00 0",
               busy, wb_s1, wb_s0, wb_boot);
    end
    cancel = 1'b0;
    for (int c = 0; c < SETTLE + HOLD; c++) begin
      tick();
      if (wb_boot === 1'b1) boots++;
    end
    total++;
    if (boots !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cancel_no_boot: got boot_cycles=%0d busy=%b want 0 0", boots, busy);
    end
  endtask

  task automatic test_fire_ignore();
    int highs;
    do_reset();
    req_image = 8'($urandom);
    req       = 4'b1000;
    enable    = 1'b1;
    tick();
    req = '0;
    for (int c = 1; c <= SETTLE; c++) tick();
    total++;
    if (wb_boot !== 1'b1) begin
      bad++;
      $display("FAIL fire_rise: got boot=%b want 1", wb_boot);
    end
    highs  = 1;
    cancel = 1'b1;
    enable = 1'b0;
    for (int c = 0; c < HOLD + 4; c++) begin
      req = 4'($urandom);
      tick();
      if (wb_boot === 1'b1) highs++;
    end
    total++;
    if (highs !== HOLD || busy !== 1'b1 || wb_boot !== 1'b0) begin
      bad++;
      $display("FAIL fire_width: got high=%0d busy=%b boot=%b want %0d 1 0",
               highs, busy, wb_boot, HOLD);
    end
    cancel = 1'b0;
  endtask

  task automatic test_async_reset();
    int w;
    logic [3:0] exp_g;
    do_reset();
    req_image = 8'($urandom) | 8'h40;
    req       = 4'b1000;
    enable    = 1'b1;
    tick();
    req = '0;
    for (int c = 1; c <= SETTLE + 1; c++) tick();
    total++;
    if (wb_boot !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre: got boot=%b want 1", wb_boot);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (wb_boot !== 1'b0 || busy !== 1'b0 || {wb_s1, wb_s0} !== 2'b00 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL arst_clear: got boot=%b busy=%b s=%b%b gnt=%b want 0 0 00 0000",
               wb_boot, busy, wb_s1, wb_s0, gnt);
    end
    tick();
    rst    = 1'b0;
    m_last = NREQ - 1;
    req       = 4'($urandom_range(1, 15)) | 4'b0001;
    req_image = 8'($urandom);
    w     = pick(req, m_last);
    exp_g = 4'b0001 << w;
    tick();
    total++;
    if (gnt !== exp_g || {wb_s1, wb_s0} !== img_of(req_image, w)) begin
      bad++;
      $display("FAIL arst_regrant: got gnt=%b s=%b%b want gnt=%b s=%b",
               gnt, wb_s1, wb_s0, exp_g, img_of(req_image, w));
    end
    req = '0;
  endtask

  task automatic test_sample_once();
    logic [1:0] exp_s;
    int extra;
    do_reset();
    req_image = 8'($urandom);
    req       = 4'b0001;
    enable    = 1'b1;
    exp_s     = img_of(req_image, 0);
    tick();
    extra = 0;
    for (int c = 1; c < SETTLE; c++) begin
      req       = 4'($urandom_range(1, 15));
      req_image = 8'($urandom);
      tick();
      if (gnt !== 4'b0) extra++;
      total++;
      if ({wb_s1, wb_s0} !== exp_s || busy !== 1'b1) begin
        bad++;
        $display("FAIL sample_once c=%0d: got s=%b%b busy=%b want s=%b busy=1",
                 c, wb_s1, wb_s0, busy, exp_s);
      end
    end
    tick();
    total++;
    if (extra !== 0 || wb_boot !== 1'b1 || {wb_s1, wb_s0} !== exp_s) begin
      bad++;
      $display("FAIL sample_boot: got extra_gnt=%0d boot=%b s=%b%b want 0 1 %b",
               extra, wb_boot, wb_s1, wb_s0, exp_s);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cancel_last();
    test_fire_ignore();
    test_async_reset();
    test_sample_once();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
